// File: rtl/polaris_bus_arbiter.sv
// Two-master (fetch/data) round-robin arbiter onto one memory bus; grant is registered (1 cycle), ack/data are combinational.
// Backpressure: a master holds its request until acked; optional watchdog under POLARIS_ARB_TIMEOUT_EN.
module polaris_bus_arbiter #(
    parameter int AW      = 64,
    parameter int DW      = 64,
    parameter int TIMEOUT = 255
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic [AW-1:0] iadr_i,
    input  logic [1:0]    isiz_i,
    output logic          iack_o,
    output logic [31:0]   idat_o,
    input  logic [AW-1:0] dadr_i,
    input  logic [DW-1:0] ddat_i,
    input  logic [1:0]    dsiz_i,
    input  logic          dsigned_i,
    input  logic          dwe_i,
    input  logic          dcyc_i,
    input  logic          dstb_i,
    output logic          dack_o,
    output logic [DW-1:0] ddat_o,
    output logic [AW-1:0] madr_o,
    output logic [DW-1:0] mdat_o,
    input  logic [DW-1:0] mdat_i,
    output logic [1:0]    msiz_o,
    output logic          msigned_o,
    output logic          mwe_o,
    output logic          mcyc_o,
    output logic          mstb_o,
    input  logic          mack_i,
    output logic          timeout_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } state_e;

    state_e state_q, state_d;
    logic   last_grant_q, last_grant_d;   // 0 = I served last, 1 = D served last
    logic   ireq, dreq, granted_req;
    logic   tmo_fire;

    assign ireq = (isiz_i != 2'b00);
    assign dreq = dcyc_i & dstb_i;

    always_comb begin
        granted_req = 1'b0;
        case (state_q)
            GNT_I:   granted_req = ireq;
            GNT_D:   granted_req = dreq;
            default: granted_req = 1'b0;
        endcase
    end

`ifdef POLARIS_ARB_TIMEOUT_EN
    localparam int CW_RAW = $clog2(TIMEOUT + 1);
    localparam int CW     = (CW_RAW < 8) ? 8 : ((CW_RAW > 16) ? 16 : CW_RAW);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Counter saturates at TO_LAST so a grant stalled with strobe low cannot wrap and re-fire.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == IDLE) begin
            cnt_d = '0;
        end else if (!mack_i && (cnt_q != TO_LAST)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tmo_fire = (cnt_q == TO_LAST) && granted_req && !mack_i;
`else
    assign tmo_fire = 1'b0;
`endif

    always_comb begin
        madr_o    = '0;
        mdat_o    = '0;
        msiz_o    = 2'b00;
        msigned_o = 1'b0;
        mwe_o     = 1'b0;
        mcyc_o    = 1'b0;
        mstb_o    = 1'b0;
        iack_o    = 1'b0;
        dack_o    = 1'b0;
        timeout_o = 1'b0;
        idat_o    = reset_i ? mdat_i[31:0] : 32'd0;
        ddat_o    = reset_i ? mdat_i : '0;
        case (state_q)
            GNT_I: begin
                madr_o = iadr_i;
                msiz_o = isiz_i;
                mcyc_o = ireq;
                mstb_o = ireq;
                iack_o = mack_i & ireq;
            end
            GNT_D: begin
                madr_o    = dadr_i;
                mdat_o    = ddat_i;
                msiz_o    = dsiz_i;
                msigned_o = dsigned_i;
                mwe_o     = dwe_i;
                mcyc_o    = dcyc_i;
                mstb_o    = dstb_i;
                dack_o    = mack_i & dreq;
            end
            default: ;
        endcase
        // Watchdog: release the bus and hand the stalled master a zero-data ack.
        if (tmo_fire) begin
            madr_o    = '0;
            mdat_o    = '0;
            msiz_o    = 2'b00;
            msigned_o = 1'b0;
            mwe_o     = 1'b0;
            mcyc_o    = 1'b0;
            mstb_o    = 1'b0;
            timeout_o = 1'b1;
            if (state_q == GNT_I) begin
                iack_o = 1'b1;
                idat_o = 32'd0;
            end else begin
                dack_o = 1'b1;
                ddat_o = '0;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (ireq && (!dreq || last_grant_q)) begin
                    state_d = GNT_I;
                end else if (dreq) begin
                    state_d = GNT_D;
                end
            end
            GNT_I: begin
                if ((mack_i && ireq) || tmo_fire) begin
                    state_d      = IDLE;
                    last_grant_d = 1'b0;
                end else if (!ireq) begin
                    state_d = IDLE;
                end
            end
            GNT_D: begin
                if ((mack_i && dreq) || tmo_fire) begin
                    state_d      = IDLE;
                    last_grant_d = 1'b1;
                end else if (!dcyc_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: tb/tb_polaris_bus_arbiter.sv
// Directed bench for polaris_bus_arbiter with a per-cycle ownership model and literal spot checks.
module tb_polaris_bus_arbiter;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic [63:0] iadr_i;
    logic [1:0]  isiz_i;
    logic        iack_o;
    logic [31:0] idat_o;
    logic [63:0] dadr_i;
    logic [63:0] ddat_i;
    logic [1:0]  dsiz_i;
    logic        dsigned_i;
    logic        dwe_i;
    logic        dcyc_i;
    logic        dstb_i;
    logic        dack_o;
    logic [63:0] ddat_o;
    logic [63:0] madr_o;
    logic [63:0] mdat_o;
    logic [63:0] mdat_i;
    logic [1:0]  msiz_o;
    logic        msigned_o;
    logic        mwe_o;
    logic        mcyc_o;
    logic        mstb_o;
    logic        mack_i;
    logic        timeout_o;

    int total = 0;
    int bad   = 0;

`ifdef POLARIS_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    localparam int TO = 4;

    polaris_bus_arbiter #(.AW(64), .DW(64), .TIMEOUT(TO)) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .iadr_i(iadr_i), .isiz_i(isiz_i), .iack_o(iack_o), .idat_o(idat_o),
        .dadr_i(dadr_i), .ddat_i(ddat_i), .dsiz_i(dsiz_i), .dsigned_i(dsigned_i),
        .dwe_i(dwe_i), .dcyc_i(dcyc_i), .dstb_i(dstb_i), .dack_o(dack_o), .ddat_o(ddat_o),
        .madr_o(madr_o), .mdat_o(mdat_o), .mdat_i(mdat_i), .msiz_o(msiz_o),
        .msigned_o(msigned_o), .mwe_o(mwe_o), .mcyc_o(mcyc_o), .mstb_o(mstb_o),
        .mack_i(mack_i), .timeout_o(timeout_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Model: who owns the bus (0 none, 1 fetch, 2 data), who was served last, and how long the grant has stalled.
    int owner  = 0;
    bit last_d = 1'b1;
    int age    = 0;
    logic b_ireq, b_dreq, b_fire;
    assign b_ireq = (isiz_i != 2'b00);
    assign b_dreq = dcyc_i & dstb_i;
    assign b_fire = TO_EN && (owner != 0) && (age >= TO) && !mack_i &&
                    ((owner == 1) ? b_ireq : b_dreq);

    always @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            owner  <= 0;
            last_d <= 1'b1;
            age    <= 0;
        end else if (owner == 0) begin
            if (b_ireq && b_dreq) owner <= last_d ? 1 : 2;
            else if (b_ireq)      owner <= 1;
            else if (b_dreq)      owner <= 2;
            age <= 1;
        end else begin
            if ((mack_i && ((owner == 1) ? b_ireq : b_dreq)) || b_fire) begin
                last_d <= (owner == 2);
                owner  <= 0;
            end else if ((owner == 1) ? !b_ireq : !dcyc_i) begin
                owner <= 0;
            end else if (!mack_i) begin
                age <= age + 1;
            end
        end
    end

    logic [63:0] e_madr, e_mdat, e_ddat;
    logic [31:0] e_idat;
    logic [1:0]  e_msiz;
    logic        e_msg, e_mwe, e_mcyc, e_mstb, e_iack, e_dack, e_to;

    always @(negedge clk_i) begin
        e_madr = '0; e_mdat = '0; e_ddat = '0; e_idat = '0; e_msiz = '0;
        e_msg = 0; e_mwe = 0; e_mcyc = 0; e_mstb = 0; e_iack = 0; e_dack = 0; e_to = 0;
        if (reset_i) begin
            e_idat = mdat_i[31:0];
            e_ddat = mdat_i;
            if (owner == 1) begin
                e_madr = iadr_i; e_msiz = isiz_i;
                e_mcyc = b_ireq; e_mstb = b_ireq; e_iack = mack_i & b_ireq;
            end else if (owner == 2) begin
                e_madr = dadr_i; e_mdat = ddat_i; e_msiz = dsiz_i; e_msg = dsigned_i;
                e_mwe = dwe_i; e_mcyc = dcyc_i; e_mstb = dstb_i; e_dack = mack_i & b_dreq;
            end
            if (b_fire) begin
                e_madr = '0; e_mdat = '0; e_msiz = '0; e_msg = 0; e_mwe = 0;
                e_mcyc = 0; e_mstb = 0; e_to = 1;
                if (owner == 1) begin e_iack = 1; e_idat = '0; end
                else begin e_dack = 1; e_ddat = '0; end
            end
        end
        chk("cyc_madr", madr_o, e_madr);
        chk("cyc_mdat", mdat_o, e_mdat);
        chk("cyc_msiz", 64'(msiz_o), 64'(e_msiz));
        chk("cyc_msigned", 64'(msigned_o), 64'(e_msg));
        chk("cyc_mwe", 64'(mwe_o), 64'(e_mwe));
        chk("cyc_mcyc", 64'(mcyc_o), 64'(e_mcyc));
        chk("cyc_mstb", 64'(mstb_o), 64'(e_mstb));
        chk("cyc_iack", 64'(iack_o), 64'(e_iack));
        chk("cyc_dack", 64'(dack_o), 64'(e_dack));
        chk("cyc_idat", 64'(idat_o), 64'(e_idat));
        chk("cyc_ddat", ddat_o, e_ddat);
        chk("cyc_timeout", 64'(timeout_o), 64'(e_to));
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk_i);
    endtask

    task automatic idle_inputs();
        isiz_i = 0; dcyc_i = 0; dstb_i = 0; dwe_i = 0; dsigned_i = 0;
        dsiz_i = 0; mack_i = 0; mdat_i = '0;
    endtask

    logic [63:0] tie_adr [8];
    logic        tie_cyc [8];

    initial begin
        reset_i = 1'b0;
        iadr_i = '0; dadr_i = '0; ddat_i = '0;
        idle_inputs();
        at_neg();
        chk("reset_mcyc", 64'(mcyc_o), 64'd0);
        chk("reset_iack", 64'(iack_o), 64'd0);
        tick(); tick();
        reset_i = 1'b1;

        // Fetch: ack on third grant cycle.
        tick();
        isiz_i = 2'b10; iadr_i = 64'hFFFF_FFFF_FFFF_FF00;
        at_neg(); chk("fetch_idle_mcyc", 64'(mcyc_o), 64'd0);
        tick(); at_neg();
        chk("fetch_madr", madr_o, 64'hFFFF_FFFF_FFFF_FF00);
        chk("fetch_mcyc", 64'(mcyc_o), 64'd1);
        chk("fetch_noack1", 64'(iack_o), 64'd0);
        tick(); at_neg(); chk("fetch_noack2", 64'(iack_o), 64'd0);
        tick(); mack_i = 1; mdat_i = 64'h13; at_neg();
        chk("fetch_iack", 64'(iack_o), 64'd1);
        chk("fetch_idat", 64'(idat_o), 64'h13);
        tick(); idle_inputs(); at_neg();
        chk("fetch_after_mcyc", 64'(mcyc_o), 64'd0);
        chk("fetch_after_iack", 64'(iack_o), 64'd0);

        // Load.
        tick();
        dcyc_i = 1; dstb_i = 1; dsiz_i = 2'b01; dsigned_i = 0; dadr_i = 64'hFFFF_FFFF_DEAD_B123;
        tick(); mack_i = 1; mdat_i = 64'hFFFC; at_neg();
        chk("load_dack", 64'(dack_o), 64'd1);
        chk("load_ddat", ddat_o, 64'hFFFC);
        chk("load_msiz", 64'(msiz_o), 64'd1);
        chk("load_msigned", 64'(msigned_o), 64'd0);
        chk("load_mwe", 64'(mwe_o), 64'd0);
        chk("load_iack", 64'(iack_o), 64'd0);
        chk("load_madr", madr_o, 64'hFFFF_FFFF_DEAD_B123);
        tick(); idle_inputs(); at_neg(); chk("load_after_mcyc", 64'(mcyc_o), 64'd0);

        // Tie with continuous acks: I, bubble, D, bubble, ...
        tick();
        iadr_i = 64'h1000; dadr_i = 64'h2000;
        isiz_i = 2'b11; dcyc_i = 1; dstb_i = 1; mack_i = 1;
        for (int k = 0; k < 8; k++) begin
            tie_cyc[k] = (k % 2 == 1);
            tie_adr[k] = (k % 2 == 0) ? 64'h0 : ((k % 4 == 1) ? 64'h1000 : 64'h2000);
        end
        for (int k = 0; k < 8; k++) begin
            if (k > 0) tick();
            at_neg();
            chk($sformatf("tie_mcyc%0d", k), 64'(mcyc_o), 64'(tie_cyc[k]));
            chk($sformatf("tie_madr%0d", k), madr_o, tie_adr[k]);
        end
        tick(); idle_inputs();

        // Store with two wait states.
        tick();
        dcyc_i = 1; dstb_i = 1; dwe_i = 1; dsiz_i = 2'b11; ddat_i = 64'hFFFC; dadr_i = 64'h1_0008;
        for (int k = 1; k <= 3; k++) begin
            tick();
            if (k == 3) mack_i = 1;
            at_neg();
            chk($sformatf("store_mwe%0d", k), 64'(mwe_o), 64'd1);
            chk($sformatf("store_mdat%0d", k), mdat_o, 64'hFFFC);
            chk($sformatf("store_madr%0d", k), madr_o, 64'h1_0008);
            chk($sformatf("store_dack%0d", k), 64'(dack_o), (k == 3) ? 64'd1 : 64'd0);
        end
        tick(); idle_inputs(); at_neg(); chk("store_after_mcyc", 64'(mcyc_o), 64'd0);

        // Fetch withdrawn mid-grant; a stray ack must be ignored.
        tick(); isiz_i = 2'b01; iadr_i = 64'h40;
        tick(); at_neg(); chk("wd_mcyc", 64'(mcyc_o), 64'd1);
        tick(); isiz_i = 0; mack_i = 1; at_neg();
        chk("wd_drop_mcyc", 64'(mcyc_o), 64'd0);
        chk("wd_drop_iack", 64'(iack_o), 64'd0);
        tick(); idle_inputs();

        // Asynchronous reset in the middle of a data grant.
        tick(); dcyc_i = 1; dstb_i = 1; dadr_i = 64'h88; mdat_i = 64'h55;
        tick(); at_neg(); chk("rst_pre_mcyc", 64'(mcyc_o), 64'd1);
        #1 reset_i = 0; mack_i = 1;
        #1;
        chk("rst_async_mcyc", 64'(mcyc_o), 64'd0);
        chk("rst_async_mstb", 64'(mstb_o), 64'd0);
        chk("rst_async_madr", madr_o, 64'd0);
        chk("rst_async_dack", 64'(dack_o), 64'd0);
        chk("rst_async_ddat", ddat_o, 64'd0);
        tick(); tick();
        reset_i = 1; idle_inputs();
        at_neg(); chk("rst_after_mcyc", 64'(mcyc_o), 64'd0);
        // After reset, I wins the first tie.
        tick(); isiz_i = 2'b01; iadr_i = 64'hA0; dcyc_i = 1; dstb_i = 1; dadr_i = 64'hB0; mack_i = 1;
        tick(); at_neg();
        chk("rst_tie_madr", madr_o, 64'hA0);
        chk("rst_tie_iack", 64'(iack_o), 64'd1);
        tick(); idle_inputs();

`ifdef POLARIS_ARB_TIMEOUT_EN
        // Hung slave: watchdog on the 4th grant cycle.
        tick(); dcyc_i = 1; dstb_i = 1; dadr_i = 64'h300; mdat_i = 64'hABCD;
        for (int k = 1; k <= 4; k++) begin
            tick(); at_neg();
            chk($sformatf("to_dack%0d", k), 64'(dack_o), (k == 4) ? 64'd1 : 64'd0);
            chk($sformatf("to_flag%0d", k), 64'(timeout_o), (k == 4) ? 64'd1 : 64'd0);
            chk($sformatf("to_mcyc%0d", k), 64'(mcyc_o), (k == 4) ? 64'd0 : 64'd1);
            if (k == 4) chk("to_ddat", ddat_o, 64'd0);
        end
        tick(); idle_inputs(); at_neg();
        chk("to_after_mcyc", 64'(mcyc_o), 64'd0);
        chk("to_after_flag", 64'(timeout_o), 64'd0);
`endif

        tick(); tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/polaris_bus_arbiter.md
Name: polaris_bus_arbiter

Overview:
- Shares one external memory bus between the PolarisCPU instruction master (I port) and data master (D port).
- Sits between the CPU and the memory/IO fabric.
- Grants one master at a time and routes address, data, size, signedness and acknowledge.
- Round-robin fairness between the two masters; optional watchdog for unacknowledged cycles.

Parameters:
- AW, 64, address width of all ports.
- DW, 64, memory/D data width; I data is the low 32 bits.
- TIMEOUT, 255, watchdog limit in clk_i cycles (used only with the optional feature); must be ≥ 2.

Ports:
clk_i  in  1  system clock, rising edge
reset_i  in  1  asynchronous reset, active-low (0 = reset)
iadr_i  in  AW  CPU fetch address
isiz_i  in  2  fetch size; nonzero = fetch request
iack_o  out  1  fetch acknowledge to CPU
idat_o  out  32  fetch data = mdat_i[31:0]
dadr_i  in  AW  CPU data address
ddat_i  in  DW  CPU store data
dsiz_i  in  2  data size code (00 = byte … 11 = dword)
dsigned_i  in  1  load sign-extend request
dwe_i  in  1  write enable
dcyc_i  in  1  data cycle request
dstb_i  in  1  data strobe
dack_o  out  1  data acknowledge to CPU
ddat_o  out  DW  load data = mdat_i
madr_o  out  AW  memory address
mdat_o  out  DW  memory write data
mdat_i  in  DW  memory read data
msiz_o  out  2  memory size code
msigned_o  out  1  sign-extend request to slave
mwe_o  out  1  memory write enable
mcyc_o  out  1  memory cycle
mstb_o  out  1  memory strobe
mack_i  in  1  memory acknowledge
timeout_o  out  1  watchdog fired (optional feature only; else tied 0)

Behaviour:
- Request definitions: ireq = (isiz_i != 0); dreq = dcyc_i & dstb_i.
- States: IDLE, GNT_I, GNT_D. State and last_grant (0 = I, 1 = D) are registers.
- Reset (reset_i = 0, asynchronous):
  - State → IDLE; last_grant → D, so I wins the first tie.
  - Every output 0.
  - Applying reset mid-transaction drops mcyc_o/mstb_o immediately; no ack is generated.
- IDLE transitions:
  - ireq only → GNT_I.
  - dreq only → GNT_D.
  - Both → the master not equal to last_grant.
  - Neither → stay in IDLE.
  - All m* outputs are 0 while in IDLE.
- Grant is registered: a request first seen at edge N drives mcyc_o high in the cycle after N. Minimum latency is 1 cycle.
- In GNT_I:
  - madr_o = iadr_i; msiz_o = isiz_i; mwe_o = 0; msigned_o = 0; mdat_o = 0.
  - mcyc_o = mstb_o = ireq.
- In GNT_D:
  - madr_o = dadr_i; msiz_o = dsiz_i; msigned_o = dsigned_i; mwe_o = dwe_i; mdat_o = ddat_i.
  - mcyc_o = dcyc_i; mstb_o = dstb_i.
- Acknowledge is combinational pass-through:
  - iack_o = mack_i & GNT_I & ireq.
  - dack_o = mack_i & GNT_D & dreq.
  - The non-granted master's ack is always 0.
- idat_o and ddat_o are routed from mdat_i continuously; their values are meaningful only when the matching ack is high.
- On an acked edge: state → IDLE and last_grant ← granted master. One bus-idle bubble always follows each transfer.
- Request withdrawn while granted (ireq/dcyc_i falls in its grant state): mcyc_o follows low the same cycle; state → IDLE next edge; last_grant unchanged.
- mack_i while in IDLE, or while the granted request is low, is ignored.
- Back-to-back requests from the same master with the other idle: served every 2 cycles plus slave wait states.

Optional Feature:
- Macro: POLARIS_ARB_TIMEOUT_EN.
- With it:
  - An 8-to-16-bit counter (width from TIMEOUT) clears on entering GNT_I/GNT_D and increments each granted cycle without mack_i.
  - When the count reaches TIMEOUT, the arbiter forces the granted master's ack high for one cycle with its data output = 0, and pulses timeout_o for that cycle.
  - Memory outputs are driven low that cycle and the state returns to IDLE.
  - A real mack_i on the same cycle as the timeout wins; timeout_o stays 0.
- Without it: no counter; timeout_o is tied 0; a hung slave holds the grant indefinitely.

Test Plan:
1. Reset: reset_i = 0 mid-GNT_D with mcyc_o = 1 → all outputs 0 asynchronously, before the next clk_i edge; after release, state is IDLE.
2. Fetch: isiz_i = 10, iadr_i = FFFF_FFFF_FFFF_FF00; mack_i = 1 on the third grant cycle with mdat_i = 0000_0000_0000_0013 → madr_o matches iadr_i one cycle after the request; iack_o = 1 and idat_o = 0000_0013 on that cycle only; mcyc_o = 0 on the next cycle.
3. Load: dcyc_i = dstb_i = 1, dsiz_i = 01, dsigned_i = 0, dadr_i = FFFF_FFFF_DEAD_B123; mack_i with mdat_i = FFFC → msiz_o = 01, msigned_o = 0, mwe_o = 0, ddat_o = FFFC when dack_o = 1; iack_o stays 0.
4. Tie and fairness: both ireq and dreq held continuously, mack_i always 1 → grant order I, D, I, D, with one IDLE cycle between each grant.
5. Store: dwe_i = 1, dsiz_i = 11, ddat_i = FFFC, dadr_i = 1_0008; mack_i delayed 2 cycles → mwe_o = 1, mdat_o = FFFC, madr_o = 1_0008 held stable until the ack.
6. With POLARIS_ARB_TIMEOUT_EN and TIMEOUT = 4: D request, mack_i held 0 → dack_o = 1, ddat_o = 0 and timeout_o = 1 on the 4th grant cycle; IDLE on the next cycle.
